// File: rtl/data_mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pkg
//  Brief    : Shared types and the alignment check for the data memory LSU.
//  Revision : 1.0
// ============================================================================
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } lsu_state_e;

    // Size code 2 is reserved and never aligned.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            SZ_WORD: ok = (offset == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_lsu_lane_ram.sv
`default_nettype none
// ============================================================================
//  Module   : lane_ram
//  Brief    : One byte lane: 1R/1W synchronous RAM, read-first on same address.
//  Revision : 1.0
// ============================================================================
module lane_ram #(
    parameter int LANE_W      = 8,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [LANE_W-1:0]              wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [LANE_W-1:0]              rdata
);

    logic [LANE_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu
//  Brief    : Byte-lane data memory with load/store front end and word bursts.
//  Revision : 1.0
// ============================================================================
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int LANE_W      = 8,
    parameter int MAX_BURST   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [1:0]                     req_size,
    input  logic                           req_signed,
    input  logic [31:0]                    req_addr,
    input  logic [$clog2(MAX_BURST):0]     req_len,
    input  logic [4*LANE_W-1:0]            req_wdata,
    output logic                           wdata_take,
    output logic                           resp_valid,
    output logic [4*LANE_W-1:0]            resp_rdata,
    output logic                           resp_fault,
    output logic                           resp_last
);

    localparam int DATA_W = 4 * LANE_W;
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int LEN_W  = $clog2(MAX_BURST) + 1;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
    localparam logic [AW-1:0]    ADDR_ONE = AW'(1);

    lsu_state_e        r_state;
    logic [LEN_W-1:0]  r_beat;
    logic [LEN_W-1:0]  r_len;
    logic [AW-1:0]     r_addr;
    logic              r_write;
    size_e             r_rsp_size;
    logic              r_rsp_signed;
    logic [1:0]        r_rsp_off;

    logic [1:0]        w_off;
    logic [AW-1:0]     w_idx;
    logic [LEN_W-1:0]  w_len_eff;
    logic              w_is_burst;
    logic              w_fault;
    logic              w_accept;
    logic              w_last_beat;
    logic [3:0]        w_be;
    logic [3:0]        w_we;
    logic [AW-1:0]     w_raddr;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata_ram;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_ext;
    logic              w_unused;

    // Address bits above the word index wrap and are intentionally dropped.
    assign w_unused    = ^req_addr[31:AW+2];

    assign w_off       = req_addr[1:0];
    assign w_idx       = req_addr[2 +: AW];
    assign w_len_eff   = (req_len == '0) ? LEN_ONE : req_len;
    assign w_is_burst  = (w_len_eff > LEN_ONE);
    assign w_fault     = !align_ok(req_size, w_off)
                       || (w_is_burst && (req_size != SZ_WORD))
                       || (w_len_eff > MAX_LEN);
    assign w_accept    = req_valid && req_ready;
    assign w_last_beat = (r_beat == (r_len - LEN_ONE));

    always_comb begin
        case (req_size)
            SZ_BYTE: w_be = 4'b0001;
            SZ_HALF: w_be = 4'b0011;
            default: w_be = 4'b1111;
        endcase
        w_be = w_be << w_off;
    end

    // Burst beats use the internal word pointer; otherwise the request address.
    always_comb begin
        w_raddr     = w_idx;
        w_waddr     = w_idx;
        w_we        = 4'b0000;
        w_wdata_ram = req_wdata << (w_off * LANE_W);
        if (r_state == BURST) begin
            w_raddr     = r_addr;
            w_waddr     = r_addr;
            w_wdata_ram = req_wdata;
            if (r_write) begin
                w_we = 4'b1111;
            end
        end else if (w_accept && req_write && !w_fault) begin
            w_we = w_be;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        lane_ram #(
            .LANE_W      (LANE_W),
            .DEPTH_WORDS (DEPTH_WORDS)
        ) u_lane_ram (
            .clk   (clk),
            .we    (w_we[g]),
            .waddr (w_waddr),
            .wdata (w_wdata_ram[g*LANE_W +: LANE_W]),
            .raddr (w_raddr),
            .rdata (w_ram_rdata[g*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_fault   <= 1'b0;
            resp_last    <= 1'b0;
            wdata_take   <= 1'b0;
            r_beat       <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_rsp_size   <= SZ_WORD;
            r_rsp_signed <= 1'b0;
            r_rsp_off    <= 2'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A burst leaves one idle tail cycle with ready still low.
                    req_ready <= 1'b1;
                    if (w_accept) begin
                        r_rsp_size   <= size_e'(req_size);
                        r_rsp_signed <= req_signed;
                        r_rsp_off    <= w_off;
                        if (w_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_last  <= 1'b1;
                        end else begin
                            if (!req_write) begin
                                resp_valid <= 1'b1;
                                resp_last  <= !w_is_burst;
                            end
                            if (w_is_burst) begin
                                r_state    <= BURST;
                                req_ready  <= 1'b0;
                                r_beat     <= LEN_ONE;
                                r_len      <= w_len_eff;
                                r_addr     <= w_idx + ADDR_ONE;
                                r_write    <= req_write;
                                wdata_take <= req_write;
                            end
                        end
                    end
                end
                BURST: begin
                    r_beat <= r_beat + LEN_ONE;
                    r_addr <= r_addr + ADDR_ONE;
                    if (!r_write) begin
                        resp_valid <= 1'b1;
                        resp_last  <= w_last_beat;
                    end
                    if (w_last_beat) begin
                        r_state    <= IDLE;
                        wdata_take <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_shift = w_ram_rdata >> (r_rsp_off * LANE_W);
        case (r_rsp_size)
            SZ_BYTE: w_ext = {{(DATA_W-LANE_W){r_rsp_signed & w_shift[LANE_W-1]}},
                              w_shift[LANE_W-1:0]};
            SZ_HALF: w_ext = {{(DATA_W-2*LANE_W){r_rsp_signed & w_shift[2*LANE_W-1]}},
                              w_shift[2*LANE_W-1:0]};
            default: w_ext = w_shift;
        endcase
        resp_rdata = (resp_valid && !resp_fault) ? w_ext : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_lsu
//  Brief    : Directed vector bench for data_mem_lsu single and burst access.
//  Revision : 1.0
// ============================================================================
module tb_data_mem_lsu;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [1:0]       req_size = 2'd0;
    logic             req_signed = 1'b0;
    logic [31:0]      req_addr = 32'd0;
    logic [LEN_W-1:0] req_len = 5'd1;
    logic [31:0]      req_wdata = 32'd0;
    logic             wdata_take;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_fault;
    logic             resp_last;

    int passed = 0;
    int total  = 0;
    int ready_low, take_hi, next_data, waited;

    typedef struct {
        logic             wr;
        logic [1:0]       size;
        logic             sgn;
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
        logic [31:0]      wdata;
        logic             exp_valid;
        logic             exp_fault;
        logic [31:0]      exp_rdata;
    } vec_t;

    vec_t vecs[19];

    data_mem_lsu u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .wdata_take (wdata_take),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .resp_last  (resp_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [LEN_W-1:0] len,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_len    = len;
        req_wdata  = wdata;
    endtask

    task automatic wait_ready(input string name);
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check(name, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        //            wr    size  sgn   addr        len   wdata          valid fault rdata
        vecs[0]  = '{1'b1, 2'd3, 1'b0, 32'h40,     5'd1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h42,     5'd1, 32'h0,        1'b1, 1'b0, 32'hFFFFDEAD};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h41,     5'd1, 32'h0,        1'b1, 1'b0, 32'h000000BE};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h43,     5'd1, 32'h0,        1'b1, 1'b0, 32'hFFFFFFDE};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h40,     5'd1, 32'h0,        1'b1, 1'b0, 32'h0000BEEF};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 32'h44,     5'd1, 32'h00000000, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h45,     5'd1, 32'h0000007F, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 32'h44,     5'd1, 32'h0,        1'b1, 1'b0, 32'h00007F00};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 32'h45,     5'd1, 32'h0,        1'b1, 1'b0, 32'h0000007F};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h43,     5'd1, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h41,     5'd1, 32'h12345678, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h40,     5'd1, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h40,     5'd1, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h42,     5'd1, 32'h0000A5A5, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h40,     5'd0, 32'h0,        1'b1, 1'b0, 32'hA5A5BEEF};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h40,     5'd4, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[16] = '{1'b0, 2'd3, 1'b0, 32'h42,     5'd4, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[17] = '{1'b1, 2'd0, 1'b0, 32'h47,     5'd1, 32'hFFFFFF12, 1'b0, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 2'd3, 1'b0, 32'h10044,  5'd1, 32'h0,        1'b1, 1'b0, 32'h12007F00};

        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_fault", {31'd0, resp_fault}, 32'd0);
        check("reset resp_last", {31'd0, resp_last}, 32'd0);
        check("reset wdata_take", {31'd0, wdata_take}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].len, vecs[i].wdata);
            check($sformatf("vec%0d ready", i), {31'd0, req_ready}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d fault", i), {31'd0, resp_fault}, {31'd0, vecs[i].exp_fault});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d rdata", i), resp_rdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d last", i), {31'd0, resp_last}, 32'd1);
            end
        end
        req_valid = 1'b0;

        // Store burst of 1,2,3,4 at 0x100.
        drive(1'b1, 2'd3, 1'b0, 32'h100, 5'd4, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        ready_low = 0;
        take_hi   = 0;
        next_data = 2;
        for (int c = 0; c < 8; c++) begin
            if (!req_ready) ready_low++;
            if (wdata_take) begin
                take_hi++;
                req_wdata = next_data;
                next_data++;
            end
            @(posedge clk); #1;
        end
        check("store burst ready low cycles", ready_low, 32'd4);
        check("store burst take cycles", take_hi, 32'd3);

        // Load burst back.
        wait_ready("load burst ready wait");
        drive(1'b0, 2'd3, 1'b0, 32'h100, 5'd4, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("load burst c%0d valid", c), {31'd0, resp_valid}, {31'd0, c <= 4});
            if (c <= 4) begin
                check($sformatf("load burst c%0d rdata", c), resp_rdata, c);
                check($sformatf("load burst c%0d last", c), {31'd0, resp_last}, {31'd0, c == 4});
            end
            @(posedge clk); #1;
        end

        // Wrap from the last word to word 0.
        wait_ready("wrap ready wait");
        drive(1'b1, 2'd3, 1'b0, 32'h1FFC, 5'd1, 32'hCAFEF00D);
        drive(1'b1, 2'd3, 1'b0, 32'h0000, 5'd1, 32'h0BADC0DE);
        drive(1'b0, 2'd3, 1'b0, 32'h1FFC, 5'd2, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wrap beat0 rdata", resp_rdata, 32'hCAFEF00D);
        check("wrap beat0 last", {31'd0, resp_last}, 32'd0);
        @(posedge clk); #1;
        check("wrap beat1 valid", {31'd0, resp_valid}, 32'd1);
        check("wrap beat1 rdata", resp_rdata, 32'h0BADC0DE);
        check("wrap beat1 last", {31'd0, resp_last}, 32'd1);

        // Reset in the middle of a long load burst.
        wait_ready("abort ready wait");
        drive(1'b0, 2'd3, 1'b0, 32'h100, 5'd8, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort beat0 valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clk); #1;
        check("abort beat1 rdata", resp_rdata, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        check("abort resp_last", {31'd0, resp_last}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 2'd3, 1'b0, 32'h104, 5'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("post-abort valid", {31'd0, resp_valid}, 32'd1);
        check("post-abort rdata", resp_rdata, 32'd2);
        check("post-abort last", {31'd0, resp_last}, 32'd1);
        @(posedge clk); #1;
        check("post-abort no stray beat", {31'd0, resp_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
